// File: rtl/mag_sq_prescale.sv
// Power |I|^2+|Q|^2 normalised by an even right-shift into the sqrt stage's 8-bit operand range.
// Define MAG_SQ_ROUND_EN for round-to-nearest on the normalising shift (truncation otherwise).
module mag_sq_prescale #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 8,
    parameter int SH_W  = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             VALID_IN,
    input  logic [IN_W-1:0]  I_IN,
    input  logic [IN_W-1:0]  Q_IN,
    output logic [OUT_W-1:0] X_OUT,
    output logic [SH_W-1:0]  SHIFT_OUT,
    output logic             VALID_OUT
);

    localparam int SQ_W  = 2*IN_W - 1;
    localparam int P_W   = 2*IN_W;
    localparam int MAX_H = (P_W > OUT_W) ? (P_W - OUT_W + 1) / 2 : 0;
    localparam logic [P_W-1:0] X_MAX_P = P_W'((1 << OUT_W) - 1);
    localparam logic [P_W:0]   X_MAX_E = (P_W+1)'((1 << OUT_W) - 1);

    // Smallest h such that p >> 2h fits in OUT_W bits; scanning downward leaves the smallest.
    function automatic logic [SH_W-1:0] half_shift(input logic [P_W-1:0] p);
        logic [SH_W-1:0] h;
        h = '0;
        for (int j = MAX_H; j >= 0; j--) begin
            if ((p >> (2*j)) <= X_MAX_P) h = SH_W'(j);
        end
        return h;
    endfunction

    function automatic logic [OUT_W-1:0] scale(input logic [P_W-1:0] p, input logic [SH_W-1:0] h);
        logic [P_W:0] ext;
        logic [P_W:0] r;
        ext = {1'b0, p};
`ifdef MAG_SQ_ROUND_EN
        if (h != '0) ext = ext + ((P_W+1)'(1) << (2*h - 1));
`endif
        r = ext >> (2*h);
        return (r > X_MAX_E) ? OUT_W'(X_MAX_E) : r[OUT_W-1:0];
    endfunction

    logic signed [IN_W-1:0] i_s, q_s;
    logic signed [P_W-1:0]  ii_full, qq_full;
    logic [SH_W-1:0]        sh_sel;

    logic [SQ_W-1:0]  ii_p1_d, ii_p1_q, qq_p1_d, qq_p1_q;
    logic             vld_p1_d, vld_p1_q;
    logic [P_W-1:0]   p_p2_d, p_p2_q;
    logic             vld_p2_d, vld_p2_q;
    logic [OUT_W-1:0] x_p3_d, x_p3_q;
    logic [SH_W-1:0]  sh_p3_d, sh_p3_q;
    logic             vld_p3_d, vld_p3_q;

    always_comb begin
        i_s      = I_IN;
        q_s      = Q_IN;
        ii_full  = i_s * i_s;
        qq_full  = q_s * q_s;
        sh_sel   = half_shift(p_p2_q);
        ii_p1_d  = ii_p1_q;
        qq_p1_d  = qq_p1_q;
        vld_p1_d = vld_p1_q;
        p_p2_d   = p_p2_q;
        vld_p2_d = vld_p2_q;
        x_p3_d   = x_p3_q;
        sh_p3_d  = sh_p3_q;
        vld_p3_d = vld_p3_q;
        if (CE) begin
            // Stage 1: per-component squares
            ii_p1_d  = SQ_W'(ii_full);
            qq_p1_d  = SQ_W'(qq_full);
            vld_p1_d = VALID_IN;
            // Stage 2: power sum
            p_p2_d   = P_W'(ii_p1_q) + P_W'(qq_p1_q);
            vld_p2_d = vld_p1_q;
            // Stage 3: even-shift normalisation
            x_p3_d   = scale(p_p2_q, sh_sel);
            sh_p3_d  = sh_sel;
            vld_p3_d = vld_p2_q;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ii_p1_q  <= '0;
            qq_p1_q  <= '0;
            vld_p1_q <= 1'b0;
            p_p2_q   <= '0;
            vld_p2_q <= 1'b0;
            x_p3_q   <= '0;
            sh_p3_q  <= '0;
            vld_p3_q <= 1'b0;
        end else begin
            ii_p1_q  <= ii_p1_d;
            qq_p1_q  <= qq_p1_d;
            vld_p1_q <= vld_p1_d;
            p_p2_q   <= p_p2_d;
            vld_p2_q <= vld_p2_d;
            x_p3_q   <= x_p3_d;
            sh_p3_q  <= sh_p3_d;
            vld_p3_q <= vld_p3_d;
        end
    end

    assign X_OUT     = x_p3_q;
    assign SHIFT_OUT = sh_p3_q;
    assign VALID_OUT = vld_p3_q;

endmodule

// File: tb/tb_mag_sq_prescale.sv
// Scoreboard bench for mag_sq_prescale: directed I/Q vectors with hand-computed results.
module tb_mag_sq_prescale;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       CE = 1'b1;
    logic       VALID_IN = 1'b0;
    logic [7:0] I_IN = '0;
    logic [7:0] Q_IN = '0;
    logic [7:0] X_OUT;
    logic [2:0] SHIFT_OUT;
    logic       VALID_OUT;

    typedef struct packed {
        logic [7:0] x;
        logic [2:0] sh;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

`ifdef MAG_SQ_ROUND_EN
    localparam int X450 = 113;
`else
    localparam int X450 = 112;
`endif

    mag_sq_prescale #(.IN_W(8), .OUT_W(8), .SH_W(3)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .VALID_IN(VALID_IN),
        .I_IN(I_IN), .Q_IN(Q_IN),
        .X_OUT(X_OUT), .SHIFT_OUT(SHIFT_OUT), .VALID_OUT(VALID_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic send(input int i, input int q, input int x, input int sh);
        exp_t e;
        @(posedge CLK);
        #1;
        VALID_IN = 1'b1;
        I_IN = 8'(i);
        Q_IN = 8'(q);
        e.x  = 8'(x);
        e.sh = 3'(sh);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            VALID_IN = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) @(posedge CLK);
        check(name, exp_q.size(), 0);
    endtask

    // Downstream consumes an output on an enabled edge; CE only changes just after posedge.
    always @(negedge CLK) begin
        if (RST && CE && VALID_OUT) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got x=%0d sh=%0d expected no output", X_OUT, SHIFT_OUT);
            end else begin
                mon_e = exp_q.pop_front();
                check("x_out", int'(X_OUT), int'(mon_e.x));
                check("shift_out", int'(SHIFT_OUT), int'(mon_e.sh));
            end
        end
    end

    initial begin
        #1;
        check("rst_x", X_OUT, 0);
        check("rst_sh", SHIFT_OUT, 0);
        check("rst_valid", VALID_OUT, 0);
        #19;
        RST = 1'b1;

        send(11, 0, 121, 0);
        idle(1);
        drain("basic_drain");

        send(-7, 0, 49, 0);
        send(4, 4, 32, 0);
        send(12, 12, 72, 1);
        send(-128, -128, 128, 4);
        send(15, 15, X450, 1);
        send(58, 27, 255, 2);
        send(0, 0, 0, 0);
        send(15, 5, 250, 0);
        send(16, 0, 64, 1);
        send(-128, 0, 64, 4);
        send(127, 127, 126, 4);
        idle(1);
        drain("stream_drain");

        send(3, 4, 25, 0);
        send(10, 10, 200, 0);
        send(20, 0, 100, 1);
        idle(1);
        @(posedge CLK);
        #1;
        CE = 1'b0;
        VALID_IN = 1'b1;
        I_IN = 8'd100;
        Q_IN = 8'd100;
        repeat (5) begin
            @(posedge CLK);
            #2;
            check("stall_valid", VALID_OUT, 1);
            check("stall_x", X_OUT, 200);
            check("stall_sh", SHIFT_OUT, 0);
        end
        @(posedge CLK);
        #1;
        CE = 1'b1;
        VALID_IN = 1'b0;
        drain("stall_drain");

        send(1, 1, 2, 0);
        send(2, 2, 8, 0);
        send(3, 3, 18, 0);
        @(posedge CLK);
        #1;
        VALID_IN = 1'b0;
        check("pre_rst_valid", VALID_OUT, 1);
        check("pre_rst_x", X_OUT, 2);
        RST = 1'b0;
        #1;
        check("mid_rst_valid", VALID_OUT, 0);
        check("mid_rst_x", X_OUT, 0);
        check("mid_rst_sh", SHIFT_OUT, 0);
        exp_q.delete();
        #1;
        RST = 1'b1;
        idle(6);
        send(5, 0, 25, 0);
        idle(1);
        drain("post_rst_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
